// File: rtl/nlm_line_buffer.sv
// Vertical line buffer feeding the NLM denoise core: keeps the last 2*WIN_RADIUS
// Bayer lines and emits one (2*WIN_RADIUS+1)-pixel column per accepted pixel,
// with top-of-frame rows clamped to the oldest line that exists.
module nlm_line_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WIN_RADIUS = 2,
  parameter int unsigned MAX_WIDTH  = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      en_i,
  input  logic                                      valid_i,
  input  logic [DATA_WIDTH-1:0]                     data_i,
  input  logic                                      frame_sync_i,
  input  logic                                      line_sync_i,
  output logic [(2*WIN_RADIUS+1)*DATA_WIDTH-1:0]    col_o,
  output logic                                      valid_o,
  output logic                                      frame_sync_o,
  output logic                                      line_sync_o,
  output logic                                      ovf_o
);

  localparam int unsigned BANKS  = 2 * WIN_RADIUS;
  localparam int unsigned ROWS   = BANKS + 1;
  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned CNT_W  = $clog2(BANKS + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d, x_eff;
  logic                  x_full_q, x_full_d, full_eff;
  logic [CNT_W-1:0]      lc_q, lc_d, lc_eff;
  logic [BANK_W-1:0]     wb_q, wb_d, wb_eff;
  logic                  accept;
  logic                  wr_en;
  logic [BANK_W-1:0]     sel [BANKS];
  logic                  use_in [BANKS];
  int unsigned           age;
  int unsigned           bank_idx;

  logic [DATA_WIDTH-1:0] mem [BANKS][MAX_WIDTH];

  // State, position and line bookkeeping registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      x_full_q <= 1'b0;
      lc_q     <= '0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x_full_q <= x_full_d;
      lc_q     <= lc_d;
      wb_q     <= wb_d;
    end
  end

  // Next state, effective pixel position and per-row bank selection
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    x_eff    = x_q;
    full_eff = x_full_q;
    lc_eff   = lc_q;
    wb_eff   = wb_q;
    x_d      = x_q;
    x_full_d = x_full_q;
    lc_d     = lc_q;
    wb_d     = wb_q;
    age      = 0;
    bank_idx = 0;
    for (int k = 0; k < BANKS; k++) begin
      sel[k]    = '0;
      use_in[k] = 1'b0;
    end

    if (!rstn && valid_i && (state_q == ACTIVE || frame_sync_i)) begin
      accept  = 1'b1;
      state_d = ACTIVE;
    end

    // Syncs reposition the pixel being accepted; frame sync dominates line sync
    if (frame_sync_i) begin
      x_eff    = '0;
      full_eff = 1'b0;
      lc_eff   = '0;
      wb_eff   = '0;
    end else if (line_sync_i) begin
      x_eff    = '0;
      full_eff = 1'b0;
      lc_eff   = (lc_q == CNT_W'(BANKS)) ? lc_q : lc_q + CNT_W'(1);
      wb_eff   = (wb_q == BANK_W'(BANKS - 1)) ? '0 : wb_q + BANK_W'(1);
    end

    wr_en = accept & ~full_eff;

    if (accept) begin
      lc_d = lc_eff;
      wb_d = wb_eff;
      if (full_eff) begin
        x_d      = x_eff;
        x_full_d = 1'b1;
      end else if (x_eff == ADDR_WIDTH'(MAX_WIDTH - 1)) begin
        x_d      = x_eff;
        x_full_d = 1'b1;
      end else begin
        x_d      = x_eff + ADDR_WIDTH'(1);
        x_full_d = 1'b0;
      end
    end

    // Row k shows the line of age BANKS-k, clamped to the oldest line of this frame
    for (int k = 0; k < BANKS; k++) begin
      age = BANKS - k;
      if (age > 32'(lc_eff)) age = 32'(lc_eff);
      bank_idx  = (32'(wb_eff) + BANKS - age) % BANKS;
      sel[k]    = BANK_W'(bank_idx);
      use_in[k] = (age == 0) | ~en_i;
    end
  end

  // Line memories: one word per bank per column, contents not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wb_eff][x_eff] <= data_i;
  end

  // Registered column, qualifiers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rstn) begin
      col_o        <= '0;
      valid_o      <= 1'b0;
      frame_sync_o <= 1'b0;
      line_sync_o  <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      valid_o      <= wr_en;
      frame_sync_o <= accept & frame_sync_i;
      line_sync_o  <= accept & line_sync_i;
      if (accept && frame_sync_i) begin
        ovf_o <= 1'b0;
      end else if (accept && full_eff) begin
        ovf_o <= 1'b1;
      end
      if (wr_en) begin
        for (int k = 0; k < BANKS; k++) begin
          col_o[k*DATA_WIDTH +: DATA_WIDTH] <= use_in[k] ? data_i : mem[sel[k]][x_eff];
        end
        col_o[(ROWS-1)*DATA_WIDTH +: DATA_WIDTH] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_nlm_line_buffer.sv
// Directed bench for nlm_line_buffer (WIN_RADIUS=2, reduced MAX_WIDTH=16).
module tb_nlm_line_buffer;

  localparam int unsigned DW    = 16;
  localparam int unsigned ROWS  = 5;
  localparam int unsigned CW    = ROWS * DW;
  localparam int unsigned MAXW  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          frame_sync_i = 1'b0;
  logic          line_sync_i = 1'b0;
  logic [CW-1:0] col_o;
  logic          valid_o, frame_sync_o, line_sync_o, ovf_o;

  int checks = 0;
  int errors = 0;

  nlm_line_buffer #(
    .DATA_WIDTH(DW), .WIN_RADIUS(2), .MAX_WIDTH(MAXW), .ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .en_i(en_i), .valid_i(valid_i), .data_i(data_i),
    .frame_sync_i(frame_sync_i), .line_sync_i(line_sync_i), .col_o(col_o),
    .valid_o(valid_o), .frame_sync_o(frame_sync_o), .line_sync_o(line_sync_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v, fs, ls;
    logic [DW-1:0] d;
    logic          ev;
    logic [CW-1:0] ecol;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one input cycle; outputs for it are visible on return
  task automatic drive(input logic v, input logic fs, input logic ls, input logic en,
                       input logic [DW-1:0] d);
    valid_i = v; frame_sync_i = fs; line_sync_i = ls; en_i = en; data_i = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] col5(input logic [DW-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Reference column: slice k holds line max(y-(4-k),0) at column x
  function automatic logic [CW-1:0] model(input int y, input int x, input int base);
    logic [CW-1:0] c;
    int ly;
    c = '0;
    for (int k = 0; k < 5; k++) begin
      ly = y - (4 - k);
      if (ly < 0) ly = 0;
      c[k*DW +: DW] = DW'(base + 16 * ly + x);
    end
    return c;
  endfunction

  // Frame with optional random holes and an optional bypass region
  task automatic run_frame(input int lines, input int width, input int base,
                           input int hole_pct, input int en_line, input int en_x);
    logic          en;
    logic [DW-1:0] d;
    int            nh;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++) begin
        nh = 0;
        while (hole_pct > 0 && nh < 4 && $urandom_range(99) < 32'(hole_pct)) begin
          drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, DW'($urandom));
          chk("hole valid_o", CW'(valid_o), CW'(0));
          nh++;
        end
        en = !(y == en_line && x >= en_x);
        d  = DW'(base + 16 * y + x);
        drive(1'b1, (y == 0 && x == 0), (x == 0), en, d);
        chk($sformatf("valid_o y%0d x%0d", y, x), CW'(valid_o), CW'(1));
        chk($sformatf("frame_sync_o y%0d x%0d", y, x), CW'(frame_sync_o), CW'(y == 0 && x == 0));
        chk($sformatf("line_sync_o y%0d x%0d", y, x), CW'(line_sync_o), CW'(x == 0));
        chk($sformatf("col_o y%0d x%0d", y, x), col_o, en ? model(y, x, base) : {5{d}});
      end
    end
  endtask

  initial begin
    // Hand-computed 3x4 frame, preceded by an ignored IDLE pixel and with one hole
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h55, 1'b0, '0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h00, 1'b1, col5(16'h00, 16'h00, 16'h00, 16'h00, 16'h00)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h01, 1'b1, col5(16'h01, 16'h01, 16'h01, 16'h01, 16'h01)};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h99, 1'b0, '0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h02, 1'b1, col5(16'h02, 16'h02, 16'h02, 16'h02, 16'h02)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h03, 1'b1, col5(16'h03, 16'h03, 16'h03, 16'h03, 16'h03)};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'h10, 1'b1, col5(16'h00, 16'h00, 16'h00, 16'h00, 16'h10)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h11, 1'b1, col5(16'h01, 16'h01, 16'h01, 16'h01, 16'h11)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h12, 1'b1, col5(16'h02, 16'h02, 16'h02, 16'h02, 16'h12)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h13, 1'b1, col5(16'h03, 16'h03, 16'h03, 16'h03, 16'h13)};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h20, 1'b1, col5(16'h00, 16'h00, 16'h00, 16'h10, 16'h20)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h21, 1'b1, col5(16'h01, 16'h01, 16'h01, 16'h11, 16'h21)};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h22, 1'b1, col5(16'h02, 16'h02, 16'h02, 16'h12, 16'h22)};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h23, 1'b1, col5(16'h03, 16'h03, 16'h03, 16'h13, 16'h23)};

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("reset col_o", col_o, '0);
    chk("reset valid_o", CW'(valid_o), CW'(0));
    chk("reset syncs", CW'({frame_sync_o, line_sync_o}), CW'(0));
    chk("reset ovf_o", CW'(ovf_o), CW'(0));
    rstn = 1'b0;

    // Scenario 1: table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].fs, tbl[i].ls, 1'b1, tbl[i].d);
      chk($sformatf("tbl%0d valid_o", i), CW'(valid_o), CW'(tbl[i].ev));
      chk($sformatf("tbl%0d frame_sync_o", i), CW'(frame_sync_o), CW'(tbl[i].ev & tbl[i].fs));
      chk($sformatf("tbl%0d line_sync_o", i), CW'(line_sync_o), CW'(tbl[i].ev & tbl[i].ls));
      if (tbl[i].ev) chk($sformatf("tbl%0d col_o", i), col_o, tbl[i].ecol);
    end

    // Scenario 2: 8-line frame, spot check line 6 x 2 afterwards via a rerun up to it
    run_frame(8, 4, 0, 0, -1, 0);
    run_frame(6, 4, 0, 0, -1, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h60);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h61);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h62);
    chk("line6 x2 col_o", col_o, col5(16'h22, 16'h32, 16'h42, 16'h52, 16'h62));

    // Scenario 3: same frame with random holes
    run_frame(8, 4, 0, 50, -1, 0);

    // Scenario 4: overlong line
    for (int x = 0; x < int'(MAXW) + 3; x++) begin
      drive(1'b1, x == 0, x == 0, 1'b1, DW'(16'h200 + x));
      if (x < int'(MAXW)) begin
        chk($sformatf("ovf line valid x%0d", x), CW'(valid_o), CW'(1));
        chk($sformatf("ovf line ovf_o x%0d", x), CW'(ovf_o), CW'(0));
      end else begin
        chk($sformatf("ovf pixel valid x%0d", x), CW'(valid_o), CW'(0));
        chk($sformatf("ovf pixel ovf_o x%0d", x), CW'(ovf_o), CW'(1));
      end
    end
    for (int x = 0; x < int'(MAXW); x++) begin
      drive(1'b1, 1'b0, x == 0, 1'b1, DW'(16'h210 + x));
      chk($sformatf("post-ovf ovf_o x%0d", x), CW'(ovf_o), CW'(1));
      chk($sformatf("post-ovf col_o x%0d", x), col_o, model(1, x, 16'h200));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ovf_o held over hole", CW'(ovf_o), CW'(1));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h300);
    chk("ovf_o cleared by frame_sync", CW'(ovf_o), CW'(0));

    // Scenario 5: bypass on line 2 from x=2, back on for line 3
    run_frame(4, 4, 16'h500, 0, 2, 2);

    // Scenario 6: reset mid-line 3
    run_frame(3, 4, 16'h600, 0, -1, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h630);
    chk("pre-reset col_o", col_o, model(3, 0, 16'h600));
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, DW'(16'h631 + i));
      chk($sformatf("in-reset col_o %0d", i), col_o, '0);
      chk($sformatf("in-reset valid_o %0d", i), CW'(valid_o), CW'(0));
      chk($sformatf("in-reset syncs %0d", i), CW'({frame_sync_o, line_sync_o, ovf_o}), CW'(0));
    end
    rstn = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h640);
    chk("idle after reset valid_o", CW'(valid_o), CW'(0));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h641);
    chk("idle after reset line_sync_o", CW'({valid_o, line_sync_o}), CW'(0));
    run_frame(2, 4, 16'h700, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
